// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control blocks: hazard FSM states,
// register-file addressing constants and parameter legality helpers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MULT_BUSY = 2'b01,
    MULT_DONE = 2'b10
  } hz_state_t;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam int MULT_CYCLES_MIN = 2;

  // A multi-cycle op needs the RUN cycle plus at least one MULT_BUSY cycle.
  function automatic bit mult_cycles_legal(input int cycles);
    return cycles >= MULT_CYCLES_MIN;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational hazard detection for the decode stage: load-use, branch
// operand hazard and control-flow redirect terms.
module hazard_match #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic                  UsesRsD,
  input  logic                  UsesRtD,
  input  logic                  BranchD,
  input  logic                  BranchTakenD,
  input  logic                  JumpD,
  input  logic                  RegWriteE,
  input  logic                  MemReadE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  MemReadM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  load_use,
  output logic                  branch_hazard,
  output logic                  redirect
);

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] w);
    return (r == w) && (w != '0);
  endfunction

  logic rs_hits_e;
  logic rt_hits_e;
  logic rs_hits_m;
  logic rt_hits_m;

  assign rs_hits_e = reg_match(RsD, WriteRegE);
  assign rt_hits_e = reg_match(RtD, WriteRegE);
  assign rs_hits_m = reg_match(RsD, WriteRegM);
  assign rt_hits_m = reg_match(RtD, WriteRegM);

  assign load_use = MemReadE && RegWriteE &&
                    ((UsesRsD && rs_hits_e) || (UsesRtD && rt_hits_e));

  // Branches compare in decode, so any in-flight producer must drain first.
  assign branch_hazard = BranchD &&
                         ((RegWriteE && (rs_hits_e || rt_hits_e)) ||
                          (MemReadM  && (rs_hits_m || rt_hits_m)));

  assign redirect = (BranchD && BranchTakenD) || JumpD;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, including the
// multi-cycle EX hold FSM and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [REG_ADDR_W-1:0]  RsD,
  input  logic [REG_ADDR_W-1:0]  RtD,
  input  logic                   UsesRsD,
  input  logic                   UsesRtD,
  input  logic                   BranchD,
  input  logic                   BranchTakenD,
  input  logic                   JumpD,
  input  logic                   RegWriteE,
  input  logic                   MemReadE,
  input  logic [REG_ADDR_W-1:0]  WriteRegE,
  input  logic                   MemReadM,
  input  logic [REG_ADDR_W-1:0]  WriteRegM,
  input  logic                   MultStartE,
  output logic                   PC_Enable,
  output logic                   Fetch_Enable,
  output logic                   Fetch_Flush,
  output logic                   Decode_Flush,
  output logic                   Execute_Hold,
  output logic [STALL_CNT_W-1:0] StallCount
);

  import pipeline_pkg::hz_state_t;
  import pipeline_pkg::RUN;
  import pipeline_pkg::MULT_BUSY;
  import pipeline_pkg::MULT_DONE;
  import pipeline_pkg::mult_cycles_legal;

  localparam int MCNT_W = $clog2(MULT_CYCLES);
  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULT_CYCLES - 2);

  if (!mult_cycles_legal(MULT_CYCLES)) begin : g_bad_mult_cycles
    $error("pipeline_hazard_ctrl: MULT_CYCLES must be at least 2");
  end

  hz_state_t               state;
  hz_state_t               state_next;
  logic [MCNT_W-1:0]       mcnt;
  logic [MCNT_W-1:0]       mcnt_next;
  logic [STALL_CNT_W-1:0]  stall_count;
  logic                    load_use;
  logic                    branch_hazard;
  logic                    redirect;
  logic                    stall;

  hazard_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_match (
    .RsD          (RsD),
    .RtD          (RtD),
    .UsesRsD      (UsesRsD),
    .UsesRtD      (UsesRtD),
    .BranchD      (BranchD),
    .BranchTakenD (BranchTakenD),
    .JumpD        (JumpD),
    .RegWriteE    (RegWriteE),
    .MemReadE     (MemReadE),
    .WriteRegE    (WriteRegE),
    .MemReadM     (MemReadM),
    .WriteRegM    (WriteRegM),
    .load_use     (load_use),
    .branch_hazard(branch_hazard),
    .redirect     (redirect)
  );

  assign stall = load_use || branch_hazard;

  // A stall outranks a redirect; the redirect stays asserted by decode and
  // is acted on in the cycle the stall clears.
  always_comb begin
    PC_Enable    = 1'b1;
    Fetch_Enable = 1'b1;
    Fetch_Flush  = 1'b0;
    Decode_Flush = 1'b0;
    Execute_Hold = 1'b0;
    state_next   = state;
    mcnt_next    = mcnt;

    case (state)
      MULT_BUSY: begin
        Execute_Hold = 1'b1;
        PC_Enable    = 1'b0;
        Fetch_Enable = 1'b0;
        if (mcnt == '0) begin
          state_next = MULT_DONE;
        end else begin
          mcnt_next = mcnt - 1'b1;
        end
      end

      // The finished op is still in EX here, so MultStartE must not retrigger.
      MULT_DONE: begin
        if (stall) begin
          PC_Enable    = 1'b0;
          Fetch_Enable = 1'b0;
          Decode_Flush = 1'b1;
          state_next   = MULT_DONE;
        end else begin
          Fetch_Flush = redirect;
          state_next  = RUN;
        end
      end

      default: begin
        if (MultStartE) begin
          Execute_Hold = 1'b1;
          PC_Enable    = 1'b0;
          Fetch_Enable = 1'b0;
          state_next   = MULT_BUSY;
          mcnt_next    = MCNT_LOAD;
        end else if (stall) begin
          PC_Enable    = 1'b0;
          Fetch_Enable = 1'b0;
          Decode_Flush = 1'b1;
        end else begin
          Fetch_Flush = redirect;
        end
        if (!MultStartE) begin
          state_next = RUN;
        end
      end
    endcase

    // While reset is held the whole front end is frozen and flushed.
    if (!Rst_n) begin
      PC_Enable    = 1'b0;
      Fetch_Enable = 1'b0;
      Fetch_Flush  = 1'b1;
      Decode_Flush = 1'b1;
      Execute_Hold = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= RUN;
      mcnt        <= '0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
      if (!PC_Enable && !(&stall_count)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  assign StallCount = stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MULT_CYCLES = 4;
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] HOLD  = 5'b00001;
  localparam logic [4:0] RSTV  = 5'b00110;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic        UsesRsD;
  logic        UsesRtD;
  logic        BranchD;
  logic        BranchTakenD;
  logic        JumpD;
  logic        RegWriteE;
  logic        MemReadE;
  logic [4:0]  WriteRegE;
  logic        MemReadM;
  logic [4:0]  WriteRegM;
  logic        MultStartE;
  logic        PC_Enable;
  logic        Fetch_Enable;
  logic        Fetch_Flush;
  logic        Decode_Flush;
  logic        Execute_Hold;
  logic [31:0] StallCount;
  logic        sat_pc_enable;
  logic        sat_fetch_enable;
  logic        sat_fetch_flush;
  logic        sat_decode_flush;
  logic        sat_execute_hold;
  logic [2:0]  sat_stall_count;

  pipeline_hazard_ctrl #(
    .MULT_CYCLES(MULT_CYCLES), .REG_ADDR_W(5), .STALL_CNT_W(32)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
    .BranchD(BranchD), .BranchTakenD(BranchTakenD), .JumpD(JumpD), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .WriteRegE(WriteRegE), .MemReadM(MemReadM), .WriteRegM(WriteRegM),
    .MultStartE(MultStartE), .PC_Enable(PC_Enable), .Fetch_Enable(Fetch_Enable),
    .Fetch_Flush(Fetch_Flush), .Decode_Flush(Decode_Flush), .Execute_Hold(Execute_Hold),
    .StallCount(StallCount)
  );

  pipeline_hazard_ctrl #(
    .MULT_CYCLES(MULT_CYCLES), .REG_ADDR_W(5), .STALL_CNT_W(3)
  ) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
    .BranchD(BranchD), .BranchTakenD(BranchTakenD), .JumpD(JumpD), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .WriteRegE(WriteRegE), .MemReadM(MemReadM), .WriteRegM(WriteRegM),
    .MultStartE(MultStartE), .PC_Enable(sat_pc_enable), .Fetch_Enable(sat_fetch_enable),
    .Fetch_Flush(sat_fetch_flush), .Decode_Flush(sat_decode_flush),
    .Execute_Hold(sat_execute_hold), .StallCount(sat_stall_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       branch;
    logic       taken;
    logic       jump;
    logic       reg_write_e;
    logic       mem_read_e;
    logic [4:0] write_reg_e;
    logic       mem_read_m;
    logic [4:0] write_reg_m;
    logic       mult;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      stim;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  int error_count = 0;
  int check_count = 0;

  // Behavioural model: remaining hold cycles, a "multiply just finished" flag,
  // and plain integer stall counters for the 32-bit and 3-bit instances.
  int     m_hold_left;
  bit     m_done;
  longint m_cnt;
  int     m_cnt_sat;
  bit     m_holding;
  bit     m_stalling;
  logic [4:0] m_exp;

  function automatic stim_t mk(int rs, int rt, bit urs, bit urt, bit br, bit tk, bit jp,
                               bit rwe, bit mre, int wre, bit mrm, int wrm, bit mult);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rs = urs; s.uses_rt = urt;
    s.branch = br; s.taken = tk; s.jump = jp; s.reg_write_e = rwe; s.mem_read_e = mre;
    s.write_reg_e = 5'(wre); s.mem_read_m = mrm; s.write_reg_m = 5'(wrm); s.mult = mult;
    return s;
  endfunction

  function automatic bit hit(int r, int w);
    return (r == w) && (w != 0);
  endfunction

  task automatic addVec(input string name, input stim_t s, input logic [4:0] exp);
    vec_t v;
    v.name = name; v.stim = s; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    RsD = s.rs; RtD = s.rt; UsesRsD = s.uses_rs; UsesRtD = s.uses_rt;
    BranchD = s.branch; BranchTakenD = s.taken; JumpD = s.jump;
    RegWriteE = s.reg_write_e; MemReadE = s.mem_read_e; WriteRegE = s.write_reg_e;
    MemReadM = s.mem_read_m; WriteRegM = s.write_reg_m; MultStartE = s.mult;
  endtask

  task automatic modelEval();
    bit lu;
    bit bh;
    bit rd;
    if (!Rst_n) begin
      m_hold_left = 0; m_done = 0; m_cnt = 0; m_cnt_sat = 0;
      m_holding = 0; m_stalling = 0; m_exp = RSTV;
      return;
    end
    lu = MemReadE && RegWriteE &&
         ((UsesRsD && hit(RsD, WriteRegE)) || (UsesRtD && hit(RtD, WriteRegE)));
    bh = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                     (MemReadM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
    rd = (BranchD && BranchTakenD) || JumpD;
    m_holding  = (m_hold_left > 0) || (!m_done && MultStartE);
    m_stalling = !m_holding && (lu || bh);
    if (m_holding)       m_exp = HOLD;
    else if (m_stalling) m_exp = STALL;
    else if (rd)         m_exp = FLUSH;
    else                 m_exp = NORM;
  endtask

  task automatic modelAdvance();
    if (!Rst_n) return;
    if (m_holding) begin
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_done = 1;
      end else begin
        m_hold_left = MULT_CYCLES - 1;
      end
    end else if (!m_stalling) begin
      m_done = 0;
    end
    if (!m_exp[4]) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt_sat < 7) m_cnt_sat++;
    end
  endtask

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/outs"}, {PC_Enable, Fetch_Enable, Fetch_Flush, Decode_Flush, Execute_Hold}, m_exp);
    checkVal({tag, "/StallCount"}, StallCount, m_cnt);
    checkVal({tag, "/sat_outs"}, {sat_pc_enable, sat_fetch_enable, sat_fetch_flush,
                                  sat_decode_flush, sat_execute_hold}, m_exp);
    checkVal({tag, "/sat_StallCount"}, sat_stall_count, m_cnt_sat);
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic runCycle(input string tag, input bit has_exp, input logic [4:0] exp);
    @(negedge Clk);
    modelEval();
    checkOutput(tag);
    if (has_exp) checkVal({tag, "/table"},
                          {PC_Enable, Fetch_Enable, Fetch_Flush, Decode_Flush, Execute_Hold}, exp);
    @(posedge Clk);
    modelAdvance();
    #1;
  endtask

  stim_t idle;
  stim_t lu_t1;

  initial begin
    longint base;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu_t1 = mk(4, 9, 1, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0);

    addVec("idle",          idle, NORM);
    addVec("lu_rt",         lu_t1, STALL);
    addVec("lu_reg0",       mk(4, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), NORM);
    addVec("lu_rt_unused",  mk(4, 9, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0), NORM);
    addVec("lu_rs",         mk(5, 1, 1, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0), STALL);
    addVec("load_no_wr",    mk(5, 1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0), NORM);
    addVec("bh_alu",        mk(8, 0, 0, 0, 1, 0, 0, 1, 0, 8, 0, 0, 0), STALL);
    addVec("bh_mem_load",   mk(2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0), STALL);
    addVec("br_taken",      mk(2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), FLUSH);
    addVec("jump",          mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), FLUSH);
    addVec("jump_lu",       mk(7, 0, 1, 0, 0, 0, 1, 1, 1, 7, 0, 0, 0), STALL);
    addVec("br_not_taken",  mk(2, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), NORM);
    addVec("br_taken_bh",   mk(8, 0, 1, 0, 1, 1, 0, 1, 0, 8, 0, 0, 0), STALL);
    addVec("alu_fwd_ok",    mk(8, 0, 1, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0), NORM);
    addVec("mem_reg0",      mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), NORM);

    Rst_n = 1'b0;
    applyStimulus(idle);
    runCycle("reset", 1, RSTV);
    runCycle("reset2", 1, RSTV);
    Rst_n = 1'b1;
    runCycle("first_after_reset", 1, NORM);
    checkVal("first_edge_no_stall", StallCount, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      runCycle(vecs[i].name, 1, vecs[i].exp);
    end

    // Load-use on $t1 lasts one cycle, then decode proceeds.
    applyStimulus(idle); runCycle("lu_pre", 1, NORM);
    base = m_cnt;
    applyStimulus(lu_t1); runCycle("lu_seq_stall", 1, STALL);
    lu_t1.mem_read_e = 0; lu_t1.reg_write_e = 0;
    applyStimulus(lu_t1); runCycle("lu_seq_resume", 1, NORM);
    checkVal("lu_seq_count", StallCount, base + 1);

    // Branch on a load result: stall with load in EX, then in MEM, then redirect.
    base = m_cnt;
    applyStimulus(mk(8, 0, 1, 0, 1, 1, 0, 1, 1, 8, 0, 0, 0)); runCycle("brload_ex", 1, STALL);
    applyStimulus(mk(8, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 8, 0)); runCycle("brload_mem", 1, STALL);
    applyStimulus(mk(8, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)); runCycle("brload_flush", 1, FLUSH);
    checkVal("brload_count", StallCount, base + 2);

    // MultStartE held five cycles: four holds, then MULT_DONE without retrigger.
    applyStimulus(idle); runCycle("mult_pre", 1, NORM);
    base = m_cnt;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) runCycle($sformatf("mult_hold%0d", i), 1, HOLD);
    runCycle("mult_done", 1, NORM);
    applyStimulus(idle); runCycle("mult_after", 1, NORM);
    checkVal("mult_count", StallCount, base + 4);

    // Asynchronous reset during the second MULT_BUSY cycle.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    runCycle("rstmult_start", 1, HOLD);
    runCycle("rstmult_busy1", 1, HOLD);
    #2 Rst_n = 1'b0;
    #1;
    modelEval();
    checkVal("rstmult_async_outs",
             {PC_Enable, Fetch_Enable, Fetch_Flush, Decode_Flush, Execute_Hold}, RSTV);
    checkVal("rstmult_async_count", StallCount, 0);
    @(posedge Clk);
    #3;
    applyStimulus(idle);
    Rst_n = 1'b1;
    runCycle("rstmult_release", 1, NORM);
    checkVal("rstmult_count_after", StallCount, 0);

    // Ten back-to-back load-use stalls saturate the 3-bit counter at 7.
    applyStimulus(lu_t1);
    lu_t1.mem_read_e = 1; lu_t1.reg_write_e = 1;
    applyStimulus(lu_t1);
    for (int i = 0; i < 10; i++) runCycle($sformatf("sat_lu%0d", i), 1, STALL);
    checkVal("sat_count3", sat_stall_count, 7);
    checkVal("sat_count32", StallCount, 10);
    applyStimulus(idle); runCycle("sat_idle", 1, NORM);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 99) < 30, $urandom_range(0, 1), $urandom_range(0, 99) < 10,
             $urandom_range(0, 1), $urandom_range(0, 99) < 40, $urandom_range(0, 3),
             $urandom_range(0, 99) < 30, $urandom_range(0, 3), $urandom_range(0, 99) < 8);
      applyStimulus(s);
      Rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      runCycle($sformatf("rand%0d", i), 0, NORM);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Generates the PC enable, the IF/ID register enable (`Fetch_Enable`) and clear, the ID/EX bubble, and the EX hold for multi-cycle multiply/divide. It sits beside the decode stage, with compare-in-decode branch resolution. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `MULT_CYCLES`, 4: total EX hold cycles for a multiply/divide; legal range ≥ 2.
- `REG_ADDR_W`, 5: register address width.
- `STALL_CNT_W`, 32: width of the stall counter.

- `Clk` input 1: rising-edge clock.
- `Rst_n` input 1: asynchronous, active-low reset.
- `RsD`, `RtD` input REG_ADDR_W: source registers of the instruction in decode.
- `UsesRsD`, `UsesRtD` input 1: decode instruction actually reads Rs/Rt.
- `BranchD`, `BranchTakenD`, `JumpD` input 1: control-flow instruction in decode; branch outcome.
- `RegWriteE`, `MemReadE` input 1: EX-stage instruction writes a register / is a load.
- `WriteRegE` input REG_ADDR_W: EX destination register.
- `MemReadM` input 1: MEM-stage instruction is a load.
- `WriteRegM` input REG_ADDR_W: MEM destination register.
- `MultStartE` input 1: multi-cycle op resident in EX.
- `PC_Enable` output 1: PC register update enable.
- `Fetch_Enable` output 1: IF/ID register load enable.
- `Fetch_Flush` output 1: clear IF/ID to NOP at next edge.
- `Decode_Flush` output 1: load bubble into ID/EX at next edge.
- `Execute_Hold` output 1: hold ID/EX and load bubble into EX/MEM.
- `StallCount` output STALL_CNT_W: cycles with `PC_Enable`=0 since reset.

## Operation
- Match(r, w): r == w && w != 0. A match on register 0 never stalls.
- Load-use (LU): `MemReadE` && `RegWriteE` && (`UsesRsD` && Match(`RsD`, `WriteRegE`) || `UsesRtD` && Match(`RtD`, `WriteRegE`)).
- Branch operand hazard (BH): `BranchD` && ((`RegWriteE` && Match(Rs/Rt, `WriteRegE`)) || (`MemReadM` && Match(Rs/Rt, `WriteRegM`))).
- Redirect (RD): (`BranchD` && `BranchTakenD`) || `JumpD`.
- FSM states: RUN, MULT_BUSY, MULT_DONE. A down-counter `mcnt` has width $clog2(MULT_CYCLES).
- RUN, in priority order:
  - `MultStartE`: `Execute_Hold`=1, `PC_Enable`=`Fetch_Enable`=0. Next state MULT_BUSY, `mcnt`←MULT_CYCLES-2.
  - Else LU||BH: `PC_Enable`=`Fetch_Enable`=0, `Decode_Flush`=1.
  - Else RD: `Fetch_Flush`=1, enables stay 1.
  - Else all enables 1, all flushes/hold 0.
- MULT_BUSY: same outputs as the `MultStartE` case; LU, BH and RD are ignored. When `mcnt`==0, go to MULT_DONE; otherwise decrement `mcnt`.
- MULT_DONE: behaves exactly as RUN but ignores `MultStartE`, since the finished op is still in EX this cycle. Next state is always RUN, unless LU/BH is active, which keeps it in MULT_DONE.
- A stall takes priority over a redirect. The redirect re-evaluates on the cycle the stall clears, so it is never lost.
- `StallCount` increments on every edge where `PC_Enable`==0 and `Rst_n`==1, and saturates at all-ones with no wrap.

## Timing
- Hazard outputs are combinational from the inputs and state. State, `mcnt` and `StallCount` are registered.
- Multiply: the cycle `MultStartE` is first seen in RUN, plus MULT_CYCLES-1 cycles in MULT_BUSY, gives exactly MULT_CYCLES hold cycles. The op leaves EX at the end of the MULT_DONE cycle.
- LU stall lasts 1 cycle.
- BH stall: 1 cycle for an ALU producer in EX. For a load producer it lasts 2 cycles, one with the load in EX and one in MEM.
- Redirect costs 1 flushed fetch slot.
- While `Rst_n`=0, asynchronously: state=RUN, `mcnt`=0, `StallCount`=0. Outputs are `PC_Enable`=0, `Fetch_Enable`=0, `Fetch_Flush`=1, `Decode_Flush`=1, `Execute_Hold`=0.
- Deasserting reset in the middle of a multiply returns to RUN. The pipeline is flushed by the reset outputs, so nothing resumes.
- The first edge after reset release counts no stall unless a hazard is present.

## Structure
- Shared package `pipeline_pkg`:
  - `hz_state_t` enum: RUN=2'b00, MULT_BUSY=2'b01, MULT_DONE=2'b10.
  - `REG_ADDR_W` and the `REG_ZERO` constant.
  - Elaboration check that MULT_CYCLES ≥ 2.
- One natural sub-module: `hazard_match`, combinational. It produces the LU/BH/RD terms and is reusable by the forwarding unit.
- The FSM, multiply counter and stall counter live in the top module.

## Test plan
- Load `$t1` in EX (`MemReadE`=1, `WriteRegE`=9), decode uses `RtD`=9 → one cycle with `PC_Enable`=0 and `Decode_Flush`=1, then normal; `StallCount`=1.
- Same stimulus with `WriteRegE`=0 → no stall, `StallCount` unchanged.
- `BranchD`=1, `RsD`=8, load to reg 8 in EX then in MEM → 2 stall cycles. When `BranchTakenD`=1, `Fetch_Flush` asserts in exactly the third cycle.
- `MultStartE` held high for 5 cycles, MULT_CYCLES=4 → `Execute_Hold`=1 for exactly 4 cycles, then 0 in MULT_DONE with no re-trigger; `StallCount`=4.
- Assert `Rst_n`=0 during the second MULT_BUSY cycle → outputs go immediately to the reset values; after release, state is RUN and `StallCount`=0.
- `STALL_CNT_W`=3 with 10 consecutive LU stalls → `StallCount` saturates at 7.
